// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: optional input synchronizer, shared sample tick,
// symmetric press/release qualification and registered rise/fall strobes.
module multi_debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150,
  parameter int SYNC_STAGES    = 2,
  parameter bit INIT_VALUE     = 1'b0,
  parameter int TICK_CNT_WIDTH = $clog2(SAMPLE_CNT_MAX) + 1,
  parameter int SAT_CNT_WIDTH  = $clog2(PULSE_CNT_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(SAMPLE_CNT_MAX - 1);
  localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE  = TICK_CNT_WIDTH'(1);
  localparam logic [SAT_CNT_WIDTH-1:0]  CNT_LAST  = SAT_CNT_WIDTH'(PULSE_CNT_MAX - 1);
  localparam logic [SAT_CNT_WIDTH-1:0]  CNT_ONE   = SAT_CNT_WIDTH'(1);
  localparam logic [WIDTH-1:0]          INIT_VEC  = {WIDTH{INIT_VALUE}};

  logic [TICK_CNT_WIDTH-1:0] tick_cnt;
  logic                      tick;
  logic [WIDTH-1:0]          s;
  logic [WIDTH-1:0]          deb_d;
  logic [SAT_CNT_WIDTH-1:0]  cnt [WIDTH];

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_ONE;
  end

  // Synchronizer flops reset to the output level so release never looks like an edge.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = glitchy_signal;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VEC;
      end else begin
        sync_q[0] <= glitchy_signal;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Any cycle of agreement clears qualification, so a glitch restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debounced_signal <= INIT_VEC;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == debounced_signal[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            debounced_signal[i] <= s[i];
            cnt[i]              <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d      <= INIT_VEC;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      deb_d      <= debounced_signal;
      rise_pulse <= debounced_signal & ~deb_d;
      fall_pulse <= ~debounced_signal & deb_d;
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Randomised scoreboard bench for multi_debouncer; the reference counts sample
// ticks since each channel last agreed with its debounced level.
module tb_multi_debouncer;
  localparam int W   = 2;
  localparam int SCM = 4;
  localparam int PCM = 3;
  localparam int SS  = 2;
  localparam bit IV  = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] glitchy_signal = '1;
  logic [W-1:0] debounced_signal;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  multi_debouncer #(
    .WIDTH(W), .SAMPLE_CNT_MAX(SCM), .PULSE_CNT_MAX(PCM),
    .SYNC_STAGES(SS), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst), .glitchy_signal(glitchy_signal),
    .debounced_signal(debounced_signal), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3*W-1:0] exp_q [$];
  logic [W-1:0]   gh [$];
  int             edge_n;
  int             last_agree [W];
  logic [W-1:0]   deb_m;
  logic [W-1:0]   deb_m1;

  function automatic void model_reset();
    edge_n = 0;
    gh.delete();
    exp_q.delete();
    for (int c = 0; c < W; c++) last_agree[c] = 0;
    deb_m  = {W{IV}};
    deb_m1 = {W{IV}};
  endfunction

  // Edges are numbered from reset release; edge n uses the input sampled at edge n-SS,
  // and samples at multiples of SCM. A channel flips once PCM ticks have passed
  // since its last agreeing edge.
  task automatic step(input logic [W-1:0] v);
    logic [W-1:0] s_v;
    logic [W-1:0] rise_e;
    logic [W-1:0] fall_e;
    glitchy_signal = v;
    @(posedge clk);
    edge_n++;
    gh.push_back(v);
    s_v    = (edge_n > SS) ? gh[edge_n-SS-1] : {W{IV}};
    rise_e = deb_m & ~deb_m1;
    fall_e = ~deb_m & deb_m1;
    deb_m1 = deb_m;
    for (int c = 0; c < W; c++) begin
      if (s_v[c] == deb_m[c]) begin
        last_agree[c] = edge_n;
      end else if ((edge_n % SCM == 0) && (edge_n / SCM - last_agree[c] / SCM >= PCM)) begin
        deb_m[c]      = s_v[c];
        last_agree[c] = edge_n;
      end
    end
    exp_q.push_back({deb_m, rise_e, fall_e});
    #1;
  endtask

  task automatic hold(input logic [W-1:0] v, input int cycles);
    for (int k = 0; k < cycles; k++) step(v);
  endtask

  // Called at posedge+1: assert reset mid-cycle and check outputs drop without a clock.
  task automatic reset_pulse(input logic [W-1:0] v);
    glitchy_signal = v;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    n_cmp++;
    if ({debounced_signal, rise_pulse, fall_pulse} !== {{W{IV}}, {W{1'b0}}, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL async_reset: got deb=%b rise=%b fall=%b, expected deb=%b rise=0 fall=0",
               debounced_signal, rise_pulse, fall_pulse, {W{IV}});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    logic [3*W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({debounced_signal, rise_pulse, fall_pulse} !== e) begin
          n_err++;
          $display("FAIL scoreboard edge %0d: got deb=%b rise=%b fall=%b, expected deb=%b rise=%b fall=%b",
                   edge_n, debounced_signal, rise_pulse, fall_pulse,
                   e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin : stimulus
    int len;
    logic [W-1:0] v;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    hold(2'b11, 6);

    for (int k = 0; k < 40; k++) step(W'($urandom_range(0, 3)));

    // Async reset with inputs high, then clean press on channel 0
    reset_pulse(2'b11);
    hold(2'b01, 16);
    // Release
    hold(2'b00, 16);
    // Glitchy press: two ticks high, one low cycle, then high
    hold(2'b01, 8);
    step(2'b00);
    hold(2'b01, 20);
    hold(2'b00, 16);
    // Simultaneous press and release on both channels
    hold(2'b11, 16);
    hold(2'b00, 16);
    // Reset after two disagreeing ticks; full requalification needed
    reset_pulse(2'b00);
    hold(2'b01, 9);
    reset_pulse(2'b01);
    hold(2'b01, 16);

    for (int k = 0; k < 80; k++) begin
      v   = W'($urandom_range(0, 3));
      len = $urandom_range(1, 16);
      if ($urandom_range(0, 19) == 0) reset_pulse(v);
      hold(v, len);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised multi-channel debouncer; successor to the single-direction press debouncer.
- Debounces both press and release per channel, with an optional input synchronizer and a programmable reset level.
- Emits single-cycle rising and falling edge strobes per channel.
- Sits between raw board inputs (buttons/switches) and the MMIO/user-logic layer; one shared sample-tick generator serves all channels.

Parameters:
- WIDTH, 1, number of independent channels.
- SAMPLE_CNT_MAX, 25000, clock cycles per sample tick; must be >= 2.
- PULSE_CNT_MAX, 150, consecutive disagreeing sample ticks needed to flip a channel; must be >= 1.
- SYNC_STAGES, 2, flops in the per-channel input synchronizer; 0 bypasses it.
- INIT_VALUE, 0, 1-bit reset level applied to every debounced output.
- TICK_CNT_WIDTH, $clog2(SAMPLE_CNT_MAX)+1, width of the sample-tick counter.
- SAT_CNT_WIDTH, $clog2(PULSE_CNT_MAX)+1, width of each per-channel counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- glitchy_signal  input  WIDTH  raw, possibly asynchronous inputs.
- debounced_signal  output  WIDTH  registered stable level per channel.
- rise_pulse  output  WIDTH  1-cycle strobe when a channel's debounced level goes 0->1.
- fall_pulse  output  WIDTH  1-cycle strobe when a channel's debounced level goes 1->0.

Behaviour:
- Reset:
  - Asserting rst at any time, including mid-count, asynchronously clears all state.
  - debounced_signal = {WIDTH{INIT_VALUE}}.
  - rise_pulse = 0, fall_pulse = 0.
  - Tick counter = 0, all channel counters = 0.
  - Synchronizer flops = INIT_VALUE, so no spurious edge after reset.
- Synchronizer:
  - s[i] is glitchy_signal[i] delayed by SYNC_STAGES clk cycles.
  - When SYNC_STAGES = 0, s[i] is glitchy_signal[i] directly.
- Sample tick:
  - Free-running counter 0..SAMPLE_CNT_MAX-1, wrapping to 0.
  - tick = 1 for exactly one cycle when the count is SAMPLE_CNT_MAX-1.
  - First tick occurs SAMPLE_CNT_MAX cycles after reset release.
- Per channel i, evaluated every cycle:
  - If s[i] == debounced_signal[i]: cnt[i] <= 0. This is an immediate clear, independent of tick, so a glitch restarts qualification.
  - Else if tick and cnt[i] == PULSE_CNT_MAX-1: debounced_signal[i] <= s[i], cnt[i] <= 0.
  - Else if tick: cnt[i] <= cnt[i]+1.
  - Else: hold.
- Flip timing: a channel flips on the PULSE_CNT_MAX-th consecutive tick at which s[i] disagrees with the debounced level. The rule is symmetric for press and release.
- cnt[i] never exceeds PULSE_CNT_MAX-1 and never wraps.
- Edge strobes:
  - Registered; asserted in the cycle immediately after debounced_signal[i] changes.
  - Each strobe lasts exactly 1 cycle.
  - rise_pulse[i] and fall_pulse[i] are never high simultaneously.
- Channels are fully independent; simultaneous flips on several channels in the same tick are all honoured.
- Worst-case latency from a stable input change to the output flip: SYNC_STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles.

Test Plan:
Bench config: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, SYNC_STAGES=2, INIT_VALUE=0.
- Reset check: assert rst mid-cycle with inputs high -> all outputs 0 immediately (async), with no rise_pulse after release.
- Clean press: hold glitchy_signal[0]=1 from reset release.
  - debounced_signal[0] rises on the 3rd tick (cycle 12 after release).
  - rise_pulse[0] is high for exactly cycle 13.
  - Channel 1 stays 0.
- Glitchy press: input[0] high for 2 ticks, low for 1 cycle, then high.
  - Counter clears; the flip needs 3 further consecutive ticks.
  - No early rise_pulse.
- Release: with debounced_signal[0]=1, drive input[0]=0 -> debounced_signal[0] falls on the 3rd subsequent disagreeing tick, and fall_pulse[0] is high for 1 cycle.
- Simultaneous edges: raise both channels in the same cycle -> both flip on the same tick, and both rise_pulse bits assert in the same cycle.
- Reset mid-count: assert rst after 2 disagreeing ticks, then release with input still high -> a full 3 new ticks are required before the flip.
